// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the sync generator and its users.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing outputs handed from the sync generator to the pixel stage and monitor pins.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   p_tick;
    logic   frame_tick;
    coord_t x;
    coord_t y;

    modport master (output hsync, vsync, video_on, p_tick, frame_tick, x, y);
    modport slave  (input  hsync, vsync, video_on, p_tick, frame_tick, x, y);

endinterface

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Pixel-rate enable: one high clock out of every CLK_DIV system clocks.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    output logic p_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // With CLK_DIV==1 the counter is pinned at 0 and the tick is always high.
    assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate h/v counters, registered active-low syncs, frame tick.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic           clk_100MHz,
    input  logic           reset_n,
    vga_sync_gen_if.master vga
);

    localparam coord_t H_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   p_tick;
    coord_t h_cnt, v_cnt;
    coord_t h_next, v_next;
    logic   hsync_q, vsync_q;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .p_tick     (p_tick)
    );

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (p_tick) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_next = h_cnt + 1'b1;
            end
        end
    end

    // Syncs are decoded from the next counts so they change on the same edge as x/y.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            hsync_q <= !((h_next >= HS_START) && (h_next <= HS_END));
            vsync_q <= !((v_next >= VS_START) && (v_next <= VS_END));
        end
    end

    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.p_tick     = p_tick;
    assign vga.x          = h_cnt;
    assign vga.y          = v_cnt;
    assign vga.video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign vga.frame_tick = p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing DUT (div 4), div-1 DUT, and a shrunken-geometry DUT for frame checks.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    vga_sync_gen_if ifa ();
    vga_sync_gen_if ifb ();
    vga_sync_gen_if ifc ();

    vga_sync_gen #(.CLK_DIV(4)) dut_a (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .vga        (ifa)
    );

    vga_sync_gen #(.CLK_DIV(1)) dut_b (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .vga        (ifb)
    );

    // Small frame: H 8+2+3+2=15, V 6+1+2+1=10, hsync x 10..12, vsync y 7..8, 300 clocks/frame.
    vga_sync_gen #(
        .CLK_DIV(2),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_c (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .vga        (ifc)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int a_hs_low, a_vid, a_xmax, a_ptk;
        int b_ptk, b_ft;
        int c_hs_low, c_vs_low, c_vid, c_ft, c_ft1, c_ft2, c_vs_bad, c_xmax, c_ymax, a_ft;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_x",   ifa.x, 0);
        chk("rst_a_y",   ifa.y, 0);
        chk("rst_a_hs",  ifa.hsync, 1);
        chk("rst_a_vs",  ifa.vsync, 1);
        chk("rst_a_vid", ifa.video_on, 1);
        chk("rst_a_ptk", ifa.p_tick, 0);
        chk("rst_a_ft",  ifa.frame_tick, 0);
        chk("rst_b_ptk", ifb.p_tick, 1);

        // Phase 1: default div-4 DUT through one line and into the next.
        reset_n = 1'b1;
        a_hs_low = 0; a_vid = 0; a_xmax = 0;
        for (int e = 1; e <= 6000; e++) begin
            @(negedge clk);
            if (e <= 3200) begin
                if (!ifa.hsync)  a_hs_low++;
                if (ifa.video_on) a_vid++;
            end
            if (int'(ifa.x) > a_xmax) a_xmax = int'(ifa.x);
            if (e == 2)    chk("a_ptk_e2", ifa.p_tick, 0);
            if (e == 3)    begin chk("a_ptk_e3", ifa.p_tick, 1); chk("a_x_e3", ifa.x, 0); end
            if (e == 4)    begin chk("a_ptk_e4", ifa.p_tick, 0); chk("a_x_e4", ifa.x, 1); end
            if (e == 7)    chk("a_ptk_e7", ifa.p_tick, 1);
            if (e == 8)    chk("a_x_e8", ifa.x, 2);
            if (e == 2556) begin chk("a_vid_x639", ifa.video_on, 1); chk("a_x639", ifa.x, 639); end
            if (e == 2560) chk("a_vid_x640", ifa.video_on, 0);
            if (e == 2620) chk("a_hs_x655", ifa.hsync, 1);
            if (e == 2624) begin chk("a_hs_x656", ifa.hsync, 0); chk("a_x656", ifa.x, 656); end
            if (e == 3004) chk("a_hs_x751", ifa.hsync, 0);
            if (e == 3008) chk("a_hs_x752", ifa.hsync, 1);
            if (e == 3196) begin chk("a_x799", ifa.x, 799); chk("a_y_l0", ifa.y, 0); end
            if (e == 3199) chk("a_ptk_e3199", ifa.p_tick, 1);
            if (e == 3200) begin
                chk("a_x_wrap", ifa.x, 0);
                chk("a_y_l1", ifa.y, 1);
                chk("a_vid_x0", ifa.video_on, 1);
            end
        end
        chk("a_hs_low_clks", a_hs_low, 384);
        chk("a_vid_clks", a_vid, 2560);
        chk("a_xmax", a_xmax, 799);
        chk("a_x700", ifa.x, 700);
        chk("a_y700", ifa.y, 1);
        chk("a_hs_x700", ifa.hsync, 0);
        chk("a_vid_x700", ifa.video_on, 0);

        // Asynchronous reset between edges, inside the hsync pulse.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_x",   ifa.x, 0);
        chk("arst_y",   ifa.y, 0);
        chk("arst_hs",  ifa.hsync, 1);
        chk("arst_vid", ifa.video_on, 1);
        chk("arst_ptk", ifa.p_tick, 0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_hold_x", ifa.x, 0);
        reset_n = 1'b1;

        // Phase 2: restart of A, div-1 DUT over two lines, small DUT over several frames.
        a_ptk = 0; b_ptk = 0; b_ft = 0; a_ft = 0;
        c_hs_low = 0; c_vs_low = 0; c_vid = 0; c_ft = 0; c_ft1 = -1; c_ft2 = -1;
        c_vs_bad = 0; c_xmax = 0; c_ymax = 0;
        for (int e = 1; e <= 1700; e++) begin
            @(negedge clk);
            if (ifa.p_tick) a_ptk++;
            if (ifa.frame_tick) a_ft++;
            if (ifb.p_tick) b_ptk++;
            if (ifb.frame_tick) b_ft++;
            if (e <= 300) begin
                if (!ifc.hsync)   c_hs_low++;
                if (!ifc.vsync)   c_vs_low++;
                if (ifc.video_on) c_vid++;
            end
            if (!ifc.vsync && (ifc.y < 7 || ifc.y > 8)) c_vs_bad++;
            if (ifc.frame_tick) begin
                c_ft++;
                if (c_ft1 < 0) c_ft1 = e;
                else if (c_ft2 < 0) c_ft2 = e;
            end
            if (int'(ifc.x) > c_xmax) c_xmax = int'(ifc.x);
            if (int'(ifc.y) > c_ymax) c_ymax = int'(ifc.y);
            if (e == 4)    begin chk("a2_x_e4", ifa.x, 1); chk("a2_y_e4", ifa.y, 0); end
            if (e == 1)    chk("b_x_e1", ifb.x, 1);
            if (e == 655)  chk("b_hs_x655", ifb.hsync, 1);
            if (e == 656)  begin chk("b_hs_x656", ifb.hsync, 0); chk("b_x656", ifb.x, 656); end
            if (e == 751)  chk("b_hs_x751", ifb.hsync, 0);
            if (e == 752)  chk("b_hs_x752", ifb.hsync, 1);
            if (e == 799)  begin chk("b_x799", ifb.x, 799); chk("b_y_l0", ifb.y, 0); end
            if (e == 800)  begin chk("b_x_wrap", ifb.x, 0); chk("b_y_l1", ifb.y, 1); end
            if (e == 1600) begin chk("b_x_l2", ifb.x, 0); chk("b_y_l2", ifb.y, 2); end
            if (e == 209)  chk("c_vs_y6", ifc.vsync, 1);
            if (e == 210)  begin chk("c_vs_y7", ifc.vsync, 0); chk("c_y7", ifc.y, 7); end
            if (e == 269)  chk("c_vs_y8", ifc.vsync, 0);
            if (e == 270)  chk("c_vs_y9", ifc.vsync, 1);
            if (e == 298)  begin chk("c_x_last", ifc.x, 14); chk("c_y_last", ifc.y, 9); end
            if (e == 300)  begin chk("c_x_wrap", ifc.x, 0); chk("c_y_wrap", ifc.y, 0); end
        end
        chk("a2_ptk_cnt", a_ptk, 425);
        chk("a2_ft_cnt", a_ft, 0);
        chk("b_ptk_cnt", b_ptk, 1700);
        chk("b_ft_cnt", b_ft, 0);
        chk("c_hs_low_clks", c_hs_low, 60);
        chk("c_vs_low_clks", c_vs_low, 60);
        chk("c_vid_clks", c_vid, 96);
        chk("c_vs_outside", c_vs_bad, 0);
        chk("c_ft_cnt", c_ft, 5);
        chk("c_ft_first", c_ft1, 299);
        chk("c_ft_period", c_ft2 - c_ft1, 300);
        chk("c_xmax", c_xmax, 14);
        chk("c_ymax", c_ymax, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
